// File: rtl/mdu_if.sv
// Pipeline <-> multiply/divide unit bundle. The master is the EX stage, the slave is mdu_iterative.
// Handshake: start is the request valid, sampled on a rising edge. It is only
// accepted while busy=0. The requester keeps start/op/a/b stable while stall=1.
// done is a one-cycle pulse marking the HI/LO commit of a MULT/DIV.
interface mdu_if #(parameter int XLEN = 32);
  logic            start;
  logic [2:0]      op;
  logic [XLEN-1:0] a;
  logic [XLEN-1:0] b;
  logic            flush;
  logic            busy;
  logic            stall;
  logic            done;
  logic [XLEN-1:0] hi;
  logic [XLEN-1:0] lo;

  modport master (output start, op, a, b, flush, input busy, stall, done, hi, lo);
  modport slave  (input start, op, a, b, flush, output busy, stall, done, hi, lo);
endinterface

// File: rtl/mdu_iterative.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning HI/LO; one bit per cycle on magnitudes,
// with sign fix-up folded into the final (FIX) cycle together with the last iteration.
module mdu_iterative #(
  parameter int XLEN = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  mdu_if.slave       bus,
  output logic [1:0] state_dbg
);
  localparam int CW = $clog2(XLEN + 1);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_MUL = 2'd1, S_DIV = 2'd2, S_FIX = 2'd3} state_t;

  state_t            state_q, state_d;
  logic              busy_q, done_q;
  logic [CW-1:0]     cnt_q;
  logic [2*XLEN-1:0] acc_q;
  logic [XLEN-1:0]   opb_q, hi_q, lo_q;
  logic              neg_q, neg_r, is_div, dz;

  logic              req, req_md, req_mul, req_div, div_zero, op_signed;
  logic [XLEN-1:0]   mag_a, mag_b;
  logic [XLEN:0]     mul_sum, rem_sh, div_diff;
  logic [2*XLEN-1:0] step, prod;
  logic [XLEN-1:0]   quot, rem, hi_fix, lo_fix;

  // Request decode; only meaningful while IDLE, and flush drops the request.
  always_comb begin
    req       = bus.start && !bus.flush;
    req_md    = req && (bus.op <= 3'd3);
    req_mul   = req_md && !bus.op[1];
    req_div   = req_md && bus.op[1];
    div_zero  = req_div && (bus.b == '0);
    op_signed = !bus.op[0];
    mag_a     = (op_signed && bus.a[XLEN-1]) ? -bus.a : bus.a;
    mag_b     = (op_signed && bus.b[XLEN-1]) ? -bus.b : bus.b;
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      busy_q  <= (state_d != S_IDLE);
    end
  end

  // Next-state logic. The counter reaching 1 hands over to FIX, which does the last step.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (req_mul)       state_d = S_MUL;
        else if (div_zero) state_d = S_FIX;
        else if (req_div)  state_d = S_DIV;
      end
      S_MUL, S_DIV: begin
        if (bus.flush)               state_d = S_IDLE;
        else if (cnt_q == CW'(2))    state_d = S_FIX;
      end
      S_FIX:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    bus.busy  = busy_q;
    bus.stall = busy_q | (bus.start & (bus.op <= 3'd3));
    bus.done  = done_q;
    bus.hi    = hi_q;
    bus.lo    = lo_q;
    state_dbg = state_q;
  end

  // One iteration step and the final sign fix-up.
  always_comb begin
    mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opb_q} : {(XLEN+1){1'b0}});
    rem_sh   = acc_q[2*XLEN-1:XLEN-1];
    div_diff = rem_sh - {1'b0, opb_q};
    if (!is_div)             step = {mul_sum, acc_q[XLEN-1:1]};
    else if (div_diff[XLEN]) step = {rem_sh[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
    else                     step = {div_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
    prod = neg_q ? -step : step;
    quot = step[XLEN-1:0];
    rem  = step[2*XLEN-1:XLEN];
    if (dz) begin
      // Divide by zero keeps the untouched dividend in the low half of acc.
      hi_fix = acc_q[XLEN-1:0];
      lo_fix = '1;
    end else if (is_div) begin
      hi_fix = neg_r ? -rem : rem;
      lo_fix = neg_q ? -quot : quot;
    end else begin
      hi_fix = prod[2*XLEN-1:XLEN];
      lo_fix = prod[XLEN-1:0];
    end
  end

  // Datapath: operand latch, iteration, commit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done_q <= 1'b0;
      cnt_q  <= '0;
      acc_q  <= '0;
      opb_q  <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      is_div <= 1'b0;
      dz     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (req_md) begin
            if (div_zero)     acc_q <= {{XLEN{1'b0}}, bus.a};
            else if (req_div) acc_q <= {{XLEN{1'b0}}, mag_a};
            else              acc_q <= {{XLEN{1'b0}}, mag_b};
            opb_q  <= req_div ? mag_b : mag_a;
            neg_q  <= op_signed & (bus.a[XLEN-1] ^ bus.b[XLEN-1]);
            neg_r  <= op_signed & bus.a[XLEN-1];
            is_div <= req_div;
            dz     <= div_zero;
            cnt_q  <= CW'(XLEN);
          end else if (req && bus.op == 3'd4) begin
            hi_q <= bus.a;
          end else if (req && bus.op == 3'd5) begin
            lo_q <= bus.a;
          end
        end
        S_MUL, S_DIV: begin
          if (!bus.flush) begin
            acc_q <= step;
            cnt_q <= cnt_q - CW'(1);
          end
        end
        S_FIX: begin
          if (!bus.flush) begin
            hi_q   <= hi_fix;
            lo_q   <= lo_fix;
            done_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_mdu_iterative.sv
// Directed bench for mdu_iterative: an arithmetic reference model checked every cycle,
// plus literal expectations taken from hand calculation.
module tb_mdu_iterative;
  localparam int XLEN = 32;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] state_dbg;
  int         tests = 0;
  int         fails = 0;
  int         done_cnt = 0;
  bit         run_chk = 1'b1;

  mdu_if #(.XLEN(XLEN)) bus ();

  mdu_iterative #(.XLEN(XLEN)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus.slave),
    .state_dbg (state_dbg)
  );

  // Clock / reset
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: {hi,lo} from plain 64-bit arithmetic.
  function automatic logic [63:0] ref_result(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    logic [63:0] ua, ub;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    case (op)
      3'd0: return 64'(sa * sb);
      3'd1: return ua * ub;
      3'd2: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
      end
      default: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        return {a % b, a / b};
      end
    endcase
  endfunction

  // Cycle model: an accepted MULT/DIV commits XLEN edges later (1 edge for divide by zero).
  logic [31:0] m_hi, m_lo, p_hi, p_lo;
  logic        m_busy, m_done;
  int          remain;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_hi = '0; m_lo = '0; p_hi = '0; p_lo = '0;
      m_busy = 1'b0; m_done = 1'b0; remain = 0;
    end else begin
      m_done = 1'b0;
      if (m_busy) begin
        if (bus.flush) m_busy = 1'b0;
        else begin
          remain--;
          if (remain == 0) begin
            m_hi = p_hi; m_lo = p_lo; m_busy = 1'b0; m_done = 1'b1;
          end
        end
      end else if (bus.start && !bus.flush) begin
        if (bus.op <= 3'd3) begin
          {p_hi, p_lo} = ref_result(bus.op, bus.a, bus.b);
          m_busy = 1'b1;
          remain = (bus.op >= 3'd2 && bus.b == 32'd0) ? 1 : XLEN;
        end else if (bus.op == 3'd4) m_hi = bus.a;
        else if (bus.op == 3'd5) m_lo = bus.a;
      end
    end
  end

  // Scoreboard compare, every cycle, away from the active edge.
  always @(posedge clk) begin
    #3;
    if (run_chk) begin
      check("cyc_busy", {31'd0, bus.busy}, {31'd0, m_busy});
      check("cyc_done", {31'd0, bus.done}, {31'd0, m_done});
      check("cyc_stall", {31'd0, bus.stall}, {31'd0, m_busy | (bus.start & (bus.op <= 3'd3))});
      check("cyc_hi", bus.hi, m_hi);
      check("cyc_lo", bus.lo, m_lo);
      if (bus.done) done_cnt++;
    end
  end

  // Driver tasks
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    bus.start = 1'b1; bus.op = op; bus.a = a; bus.b = b;
    @(negedge clk);
    bus.start = 1'b0; bus.op = 3'd7;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    do begin
      @(posedge clk); #3; n++;
    end while (!bus.done && n < 40);
    if (!bus.done) begin
      tests++; fails++;
      $display("FAIL done_timeout actual=no_done required=done within 40 cycles");
    end
  endtask

  task automatic run_md(input string name, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el,
                        input int lat);
    int n;
    issue(op, a, b);
    wait_done(n);
    check({name, "_lat"}, 32'(n), 32'(lat));
    check({name, "_hi"}, bus.hi, eh);
    check({name, "_lo"}, bus.lo, el);
  endtask

  initial begin
    bus.start = 1'b0; bus.op = 3'd7; bus.a = '0; bus.b = '0; bus.flush = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_hi", bus.hi, 32'd0);
    check("rst_lo", bus.lo, 32'd0);
    check("rst_busy", {31'd0, bus.busy}, 32'd0);
    check("rst_done", {31'd0, bus.done}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Latency counts edges after the sampling edge.
    run_md("mult_neg3x7", 3'd0, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 32);
    run_md("multu_max", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 32);
    run_md("div_m7_2", 3'd2, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 32);
    run_md("divu_100_7", 3'd3, 32'd100, 32'd7, 32'd2, 32'd14, 32);
    run_md("div_by_zero", 3'd2, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF, 1);
    run_md("divu_by_zero", 3'd3, 32'hFFFF_FFF0, 32'd0, 32'hFFFF_FFF0, 32'hFFFF_FFFF, 1);
    run_md("div_ovf", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 32);
    run_md("mult_negneg", 3'd0, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd0, 32'd6, 32);
    run_md("div_7_m2", 3'd2, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD, 32);

    issue(3'd4, 32'h1234_5678, 32'd0);
    check("mthi_hi", bus.hi, 32'h1234_5678);
    check("mthi_busy", {31'd0, bus.busy}, 32'd0);
    issue(3'd5, 32'hCAFE_BABE, 32'd0);
    check("mtlo_lo", bus.lo, 32'hCAFE_BABE);
    check("mtlo_busy", {31'd0, bus.busy}, 32'd0);

    // Flush together with a request in IDLE drops the request.
    @(negedge clk);
    bus.start = 1'b1; bus.op = 3'd4; bus.a = 32'hDEAD_BEEF; bus.flush = 1'b1;
    @(negedge clk);
    bus.start = 1'b0; bus.op = 3'd7; bus.flush = 1'b0;
    check("idle_flush_hi", bus.hi, 32'h1234_5678);

    // Flush mid-MULT
    done_cnt = 0;
    issue(3'd0, 32'd1000, 32'd1000);
    repeat (8) @(negedge clk);
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    check("flush_busy", {31'd0, bus.busy}, 32'd0);
    repeat (40) @(negedge clk);
    check("flush_no_done", 32'(done_cnt), 32'd0);
    check("flush_hi", bus.hi, 32'h1234_5678);
    check("flush_lo", bus.lo, 32'hCAFE_BABE);

    // Reset mid-MULT
    issue(3'd0, 32'd1000, 32'd1000);
    repeat (8) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rstmid_hi", bus.hi, 32'd0);
    check("rstmid_lo", bus.lo, 32'd0);
    check("rstmid_busy", {31'd0, bus.busy}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    check("rstmid_no_done", 32'(done_cnt), 32'd0);

    // Back-to-back: run_md issues in the very cycle done is high.
    run_md("b2b_multu", 3'd1, 32'h0001_0000, 32'h0001_0000, 32'd1, 32'd0, 32);
    run_md("b2b_divu", 3'd3, 32'hFFFF_FFFF, 32'd16, 32'd15, 32'h0FFF_FFFF, 32);

    repeat (2) @(negedge clk);
    run_chk = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end
endmodule
